// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the main-RAM arbiter.
// Used by mem_arb_pick and mem_arbiter.
package mem_arb_pkg;

   localparam int MEM_ADDR_W = 20;
   localparam int MEM_LINE_W = 128;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

   typedef enum logic {
      ARB_IC = 1'b0,
      ARB_DC = 1'b1
   } arb_id_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between I-cache and D-cache requests.
// MEM_ARB_RR_EN: tie goes to the requester not granted last; otherwise D-cache wins ties.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic    ic_req,
   input  logic    dc_req,
`ifdef MEM_ARB_RR_EN
   input  arb_id_e last_id,
`endif
   output logic    grant_valid,
   output arb_id_e grant_id
);

   always_comb begin
      grant_valid = ic_req | dc_req;
      grant_id    = ARB_IC;
      if (ic_req && dc_req) begin
`ifdef MEM_ARB_RR_EN
         if (last_id == ARB_IC) begin
            grant_id = ARB_DC;
         end else begin
            grant_id = ARB_IC;
         end
`else
         grant_id = ARB_DC;
`endif
      end else if (dc_req) begin
         grant_id = ARB_DC;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port main RAM arbiter for I-cache fills and D-cache fills/writebacks.
// Optional MEM_ARB_RR_EN selects round-robin tie-breaking instead of fixed D-cache priority.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no transaction; grant the winning requester and latch it
//   ACCESS | RAM busy, latency counter runs down; capture line at 0
//   RESP   | one-cycle ack to the winner, line register valid
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = MEM_ADDR_W,
   parameter int LINE_W      = MEM_LINE_W,
   parameter int MEM_LATENCY = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic              ic_ack,
   output logic [LINE_W-1:0] ic_rdata,
   input  logic              dc_req,
   input  logic              dc_we,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [LINE_W-1:0] dc_wdata,
   output logic              dc_ack,
   output logic [LINE_W-1:0] dc_rdata,
   output logic [ADDR_W-1:0] mem_rd_addr,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [LINE_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [LINE_W-1:0] mem_rdata
);

   localparam int               CNT_W    = $clog2(MEM_LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

   arb_state_e        state;
   arb_state_e        state_nxt;
   logic [CNT_W-1:0]  count;
   arb_id_e           lat_id;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [LINE_W-1:0] lat_wdata;
   logic [LINE_W-1:0] line_q;
   logic              grant_valid;
   arb_id_e           grant_id;

`ifdef MEM_ARB_RR_EN
   arb_id_e           last_id;

   mem_arb_pick u_pick (
      .ic_req      (ic_req),
      .dc_req      (dc_req),
      .last_id     (last_id),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         last_id <= ARB_IC;
      end else if (state == IDLE && grant_valid) begin
         last_id <= grant_id;
      end
   end
`else
   mem_arb_pick u_pick (
      .ic_req      (ic_req),
      .dc_req      (dc_req),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ic_ack    = 1'b0;
      dc_ack    = 1'b0;
      mem_we    = 1'b0;
      case (state)
         IDLE: begin
            if (grant_valid) begin
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            // the write strobe fires once, on the cycle the counter is still at its start value
            mem_we = lat_we && (count == CNT_INIT);
            if (count == '0) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            ic_ack    = (lat_id == ARB_IC);
            dc_ack    = (lat_id == ARB_DC);
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count     <= '0;
         lat_id    <= ARB_IC;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         line_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  count  <= CNT_INIT;
                  lat_id <= grant_id;
                  if (grant_id == ARB_DC) begin
                     lat_addr  <= dc_addr;
                     lat_we    <= dc_we;
                     lat_wdata <= dc_wdata;
                  end else begin
                     lat_addr <= ic_addr;
                     lat_we   <= 1'b0;
                  end
               end
            end
            ACCESS: begin
               if (count == '0) begin
                  line_q <= mem_rdata;
               end else begin
                  count <= count - CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // RAM read port takes a word address, write port a line index
   assign mem_rd_addr = {lat_addr[ADDR_W-3:0], 2'b00};
   assign mem_wr_addr = lat_addr;
   assign mem_wdata   = lat_wdata;
   assign ic_rdata    = line_q;
   assign dc_rdata    = line_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small line-organised RAM model.
module tb_mem_arbiter;

   localparam int ADDR_W      = 20;
   localparam int LINE_W      = 128;
   localparam int MEM_LATENCY = 5;
   localparam int L           = MEM_LATENCY;

   localparam logic [LINE_W-1:0] LINE_400 = 128'h33333333_22222222_11111111_AAAAAAAA;
   localparam logic [LINE_W-1:0] LINE_020 = 128'hCAFEF00D_0BADBEEF_12345678_9ABCDEF0;

   logic              clk;
   logic              reset;
   logic              ic_req;
   logic [ADDR_W-1:0] ic_addr;
   logic              ic_ack;
   logic [LINE_W-1:0] ic_rdata;
   logic              dc_req;
   logic              dc_we;
   logic [ADDR_W-1:0] dc_addr;
   logic [LINE_W-1:0] dc_wdata;
   logic              dc_ack;
   logic [LINE_W-1:0] dc_rdata;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [LINE_W-1:0] mem_wdata;
   logic              mem_we;
   logic [LINE_W-1:0] mem_rdata;

   int n_vec;
   int n_err;
   int we_pulses;
   int dual_ack;

   logic              ram_clr;
   logic [LINE_W-1:0] ram        [4096];
   logic              ram_wr_vld [4096];
   logic [11:0]       rd_idx;

   mem_arbiter #(
      .ADDR_W      (ADDR_W),
      .LINE_W      (LINE_W),
      .MEM_LATENCY (MEM_LATENCY)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ic_req      (ic_req),
      .ic_addr     (ic_addr),
      .ic_ack      (ic_ack),
      .ic_rdata    (ic_rdata),
      .dc_req      (dc_req),
      .dc_we       (dc_we),
      .dc_addr     (dc_addr),
      .dc_wdata    (dc_wdata),
      .dc_ack      (dc_ack),
      .dc_rdata    (dc_rdata),
      .mem_rd_addr (mem_rd_addr),
      .mem_wr_addr (mem_wr_addr),
      .mem_wdata   (mem_wdata),
      .mem_we      (mem_we),
      .mem_rdata   (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [LINE_W-1:0] init_line(input logic [11:0] idx);
      logic [31:0] w;
      w = {20'h0, idx};
      if (idx == 12'h400) return LINE_400;
      if (idx == 12'h020) return LINE_020;
      return {w, w, w, w};
   endfunction

   assign rd_idx    = mem_rd_addr[13:2];
   assign mem_rdata = ram_wr_vld[rd_idx] ? ram[rd_idx] : init_line(rd_idx);

   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 4096; i++) ram_wr_vld[i] <= 1'b0;
      end else if (mem_we) begin
         ram[mem_wr_addr[11:0]]        <= mem_wdata;
         ram_wr_vld[mem_wr_addr[11:0]] <= 1'b1;
      end
   end

   initial begin
      we_pulses = 0;
      dual_ack  = 0;
      forever begin
         @(negedge clk);
         if (mem_we === 1'b1) we_pulses++;
         if (ic_ack === 1'b1 && dc_ack === 1'b1) dual_ack++;
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      ic_req = 1'b0;
      dc_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic wait_ack(input bit want_dc, output int cyc);
      cyc = -1;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         #1;
         if ((want_dc && dc_ack === 1'b1) || (!want_dc && ic_ack === 1'b1)) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         n_vec++;
         if ({ic_ack, dc_ack, mem_we} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_idle_strobes cyc%0d got=%b want=000", i, {ic_ack, dc_ack, mem_we});
         end
         n_vec++;
         if (mem_rd_addr !== '0) begin
            n_err++;
            $display("FAIL reset_idle_rd_addr cyc%0d got=%h want=0", i, mem_rd_addr);
         end
      end
   endtask

   task automatic test_ic_read();
      int cyc;
      ic_addr = 20'h00400;
      ic_req  = 1'b1;
      @(posedge clk);
      #1;
      n_vec++;
      if (mem_rd_addr !== 20'h01000) begin
         n_err++;
         $display("FAIL ic_rd_addr got=%h want=01000", mem_rd_addr);
      end
      wait_ack(1'b0, cyc);
      if (cyc > 0) cyc = cyc + 1;
      n_vec++;
      if (cyc !== L + 1) begin
         n_err++;
         $display("FAIL ic_ack_latency got=%0d want=%0d", cyc, L + 1);
      end
      n_vec++;
      if (ic_rdata[31:0] !== 32'hAAAAAAAA) begin
         n_err++;
         $display("FAIL ic_rdata_w0 got=%h want=aaaaaaaa", ic_rdata[31:0]);
      end
      ic_req = 1'b0;
      @(posedge clk);
      #1;
      n_vec++;
      if (ic_ack !== 1'b0) begin
         n_err++;
         $display("FAIL ic_ack_width got=%b want=0", ic_ack);
      end
   endtask

   task automatic test_dc_write_read();
      int cyc;
      int we0;
      we0      = we_pulses;
      dc_we    = 1'b1;
      dc_addr  = 20'h00010;
      dc_wdata = 128'h1;
      dc_req   = 1'b1;
      @(posedge clk);
      #1;
      n_vec++;
      if ({mem_we, mem_wr_addr} !== {1'b1, 20'h00010}) begin
         n_err++;
         $display("FAIL dc_wr_strobe got=%b/%h want=1/00010", mem_we, mem_wr_addr);
      end
      wait_ack(1'b1, cyc);
      if (cyc > 0) cyc = cyc + 1;
      n_vec++;
      if (cyc !== L + 1) begin
         n_err++;
         $display("FAIL dc_wr_ack_latency got=%0d want=%0d", cyc, L + 1);
      end
      n_vec++;
      if (we_pulses - we0 !== 1) begin
         n_err++;
         $display("FAIL dc_wr_we_pulses got=%0d want=1", we_pulses - we0);
      end
      n_vec++;
      if (ram[16] !== 128'h1) begin
         n_err++;
         $display("FAIL dc_wr_ram_line got=%h want=1", ram[16]);
      end
      dc_req = 1'b0;
      dc_we  = 1'b0;
      @(posedge clk);
      #1;
      dc_req = 1'b1;
      wait_ack(1'b1, cyc);
      n_vec++;
      if (cyc !== L + 1) begin
         n_err++;
         $display("FAIL dc_rd_ack_latency got=%0d want=%0d", cyc, L + 1);
      end
      n_vec++;
      if (dc_rdata !== 128'h1) begin
         n_err++;
         $display("FAIL dc_rd_data got=%h want=1", dc_rdata);
      end
      n_vec++;
      if (we_pulses - we0 !== 1) begin
         n_err++;
         $display("FAIL dc_rd_no_write got=%0d want=1", we_pulses - we0);
      end
      dc_req = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_tie();
      int ic_cyc;
      int dc_cyc;
      logic [LINE_W-1:0] ic_d;
      logic [LINE_W-1:0] dc_d;
      do_reset();
      ic_cyc  = -1;
      dc_cyc  = -1;
      ic_d    = '0;
      dc_d    = '0;
      ic_addr = 20'h00400;
      dc_addr = 20'h00010;
      dc_we   = 1'b0;
      ic_req  = 1'b1;
      dc_req  = 1'b1;
      for (int i = 1; i <= 60 && (ic_cyc < 0 || dc_cyc < 0); i++) begin
         @(posedge clk);
         #1;
         if (dc_ack === 1'b1) begin
            dc_cyc = i;
            dc_d   = dc_rdata;
            dc_req = 1'b0;
         end
         if (ic_ack === 1'b1) begin
            ic_cyc = i;
            ic_d   = ic_rdata;
            ic_req = 1'b0;
         end
      end
      n_vec++;
      if (dc_cyc !== L + 1) begin
         n_err++;
         $display("FAIL tie_dc_ack_cycle got=%0d want=%0d", dc_cyc, L + 1);
      end
      n_vec++;
      if (ic_cyc !== 2 * L + 3) begin
         n_err++;
         $display("FAIL tie_ic_ack_cycle got=%0d want=%0d", ic_cyc, 2 * L + 3);
      end
      n_vec++;
      if (dc_d !== 128'h1) begin
         n_err++;
         $display("FAIL tie_dc_data got=%h want=1", dc_d);
      end
      n_vec++;
      if (ic_d !== LINE_400) begin
         n_err++;
         $display("FAIL tie_ic_data got=%h want=%h", ic_d, LINE_400);
      end
      ic_req = 1'b0;
      dc_req = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_arb_order();
      int ord [4];
      int expo[4];
      int n;
      int ic_left;
      int dc_left;
`ifdef MEM_ARB_RR_EN
      expo = '{1, 0, 1, 0};
`else
      expo = '{1, 1, 0, 0};
`endif
      ord     = '{-1, -1, -1, -1};
      do_reset();
      n       = 0;
      ic_left = 2;
      dc_left = 2;
      ic_addr = 20'h00400;
      dc_addr = 20'h00020;
      dc_we   = 1'b0;
      ic_req  = 1'b1;
      dc_req  = 1'b1;
      for (int i = 0; i < 80 && n < 4; i++) begin
         @(posedge clk);
         #1;
         if (dc_ack === 1'b1 && n < 4) begin
            ord[n] = 1;
            n++;
            dc_left--;
            if (dc_left == 0) dc_req = 1'b0;
         end
         if (ic_ack === 1'b1 && n < 4) begin
            ord[n] = 0;
            n++;
            ic_left--;
            if (ic_left == 0) ic_req = 1'b0;
         end
      end
      for (int k = 0; k < 4; k++) begin
         n_vec++;
         if (ord[k] !== expo[k]) begin
            n_err++;
            $display("FAIL arb_order[%0d] got=%0d want=%0d (1=dc 0=ic)", k, ord[k], expo[k]);
         end
      end
      ic_req = 1'b0;
      dc_req = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int acks;
      int cyc;
      do_reset();
      acks    = 0;
      ic_addr = 20'h00400;
      ic_req  = 1'b1;
      @(posedge clk);
      #1;
      if (L >= 2) begin
         @(posedge clk);
         #1;
      end
      if (ic_ack === 1'b1) acks++;
      reset  = 1'b1;
      ic_req = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 2 * L + 6; i++) begin
         if (ic_ack === 1'b1 || dc_ack === 1'b1) acks++;
         @(posedge clk);
         #1;
      end
      n_vec++;
      if (acks !== 0) begin
         n_err++;
         $display("FAIL reset_mid_no_ack got=%0d want=0", acks);
      end
      ic_req = 1'b1;
      wait_ack(1'b0, cyc);
      n_vec++;
      if (cyc !== L + 1) begin
         n_err++;
         $display("FAIL reset_mid_reissue_latency got=%0d want=%0d", cyc, L + 1);
      end
      n_vec++;
      if (ic_rdata !== LINE_400) begin
         n_err++;
         $display("FAIL reset_mid_reissue_data got=%h want=%h", ic_rdata, LINE_400);
      end
      ic_req = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      logic [ADDR_W-1:0] addrs [3];
      logic [LINE_W-1:0] datas [3];
      int cyc;
      int prev;
      addrs = '{20'h00010, 20'h00400, 20'h00020};
      datas = '{128'h1, LINE_400, LINE_020};
      do_reset();
      prev    = 0;
      dc_we   = 1'b0;
      dc_addr = addrs[0];
      dc_req  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_ack(1'b1, cyc);
         n_vec++;
         if (cyc !== ((k == 0) ? L + 1 : L + 2)) begin
            n_err++;
            $display("FAIL b2b_interval[%0d] got=%0d want=%0d", k, cyc, (k == 0) ? L + 1 : L + 2);
         end
         n_vec++;
         if (dc_rdata !== datas[k]) begin
            n_err++;
            $display("FAIL b2b_data[%0d] got=%h want=%h", k, dc_rdata, datas[k]);
         end
         prev = prev + cyc;
         if (k < 2) dc_addr = addrs[k+1];
         else dc_req = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      ram_clr  = 1'b1;
      reset    = 1'b1;
      ic_req   = 1'b0;
      ic_addr  = '0;
      dc_req   = 1'b0;
      dc_we    = 1'b0;
      dc_addr  = '0;
      dc_wdata = '0;
      repeat (2) @(posedge clk);
      #1 ram_clr = 1'b0;

      test_reset();
      test_ic_read();
      test_dc_write_read();
      test_tie();
      test_arb_order();
      test_reset_mid();
      test_back_to_back();

      n_vec++;
      if (dual_ack !== 0) begin
         n_err++;
         $display("FAIL dual_ack_cycles got=%0d want=0", dual_ack);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
